datapath_v2: RTL and testbench
==============================

# datapath_v2

Parametrised successor to the 16×16 register-file datapath: `NREGS` registers of `WIDTH` bits, with register 0 acting as the program counter. The external ALU result is written back directly. Loads and stores go through a valid/ready memory/stack bus whose latency is variable, using a wait-state FSM with `busy`, a timeout, and a sticky error bit. It sits between the control unit, which drives selects and commands, and the memory/stack block.

## Interface
Parameters:
- `WIDTH`, 16, register/data/address width (≥4)
- `NREGS`, 16, register count (power of two, ≥2); `SEL_W = $clog2(NREGS)` is derived
- `TIMEOUT`, 255, maximum wait cycles for `mem_ready`; 0 disables the timeout

Ports:
- `clock`  in  1  single clock, rising edge
- `resetn`  in  1  synchronous, active-low reset
- `pc_increment`  in  1  amount added to PC for the current command
- `rd_a_sel`, `rd_b_sel`, `rd_c_sel`  in  SEL_W  read-port selects
- `rd_a`, `rd_b`, `rd_c`  out  WIDTH  combinational register reads
- `wr_sel`  in  SEL_W  destination register
- `wr_src`  in  2  00 = none, 01 = ALU, 10 = memory load, 11 = stack load
- `st_mem`, `st_stk`  in  1  store `rd_c` to memory / stack at `alu_result`
- `alu_result`  in  WIDTH  writeback value, or address for loads/stores
- `mem_req`  out  1  bus request (registered)
- `mem_we`  out  1  1 = store
- `mem_space`  out  1  0 = memory, 1 = stack
- `mem_addr`, `mem_wdata`  out  WIDTH  bus address and store data (registered)
- `mem_ready`  in  1  bus completion strobe
- `mem_rdata`  in  WIDTH  load data, valid while `mem_ready` is high
- `busy`  out  1  high while in a wait state; commands are ignored
- `errorbit`  out  1  sticky; set on an illegal command or a timeout
- `zero_flags`, `sign_flags`  out  NREGS  per register: `reg==0` and `reg[WIDTH-1]`
- `registers`  out  NREGS*WIDTH  flat view; register i occupies `[i*WIDTH +: WIDTH]`

## Operation
FSM states are IDLE, LOAD_WAIT and STORE_WAIT. Commands are sampled only in IDLE.

- **IDLE, `wr_src`=00, no store:** PC ← PC + `pc_increment`.
- **IDLE, `wr_src`=01:**
  - `reg[wr_sel]` ← `alu_result`.
  - If `wr_sel`=0, PC ← `alu_result` + `pc_increment`; otherwise PC ← PC + `pc_increment`.
  - Stays in IDLE.
- **IDLE, `wr_src`=1x:**
  - Latch `wr_sel` and `pc_increment`.
  - Set `mem_req`=1, `mem_we`=0, `mem_space`=`wr_src[0]`, `mem_addr`=`alu_result`.
  - Go to LOAD_WAIT; PC is held.
- **IDLE, exactly one of `st_mem`/`st_stk` with `wr_src`=00:**
  - Latch `pc_increment`.
  - Set `mem_req`=1, `mem_we`=1, `mem_space`=`st_stk`, `mem_addr`=`alu_result`, `mem_wdata`=`rd_c`.
  - Go to STORE_WAIT.
- **Illegal commands:** `st_mem`&`st_stk` together, or any store together with `wr_src`≠00.
  - Set `errorbit`; no register or bus effect.
  - PC ← PC + `pc_increment`.
- **LOAD_WAIT with `mem_ready`:**
  - `reg[latched sel]` ← `mem_rdata`.
  - PC ← (sel=0 ? `mem_rdata` : PC) + latched increment.
  - Drop `mem_req`; go to IDLE.
- **STORE_WAIT with `mem_ready`:** PC ← PC + latched increment; drop `mem_req`; go to IDLE.
- **Timeout:** the wait counter resets on entry and increments on each wait cycle without `mem_ready`. If it reaches `TIMEOUT` (TIMEOUT≠0):
  - Set `errorbit` and drop `mem_req`.
  - No register write; PC ← PC + latched increment.
  - Go to IDLE.
- **Bus signal stability:** `mem_addr`, `mem_we`, `mem_space` and `mem_wdata` stay stable while `mem_req`=1.
- **Arithmetic:** all PC arithmetic wraps modulo 2^WIDTH.
- **Reads:** read ports are combinational. A read during a write cycle returns the old value.
- **Outputs:** `busy` = (state≠IDLE). Flags and `registers` are combinational from the register array.

## Timing
- **Reset (`resetn`=0 at an edge):**
  - All registers = 0, state = IDLE, wait counter = 0.
  - `mem_req`=0, `mem_we`=0, `mem_space`=0, `mem_addr`=0, `mem_wdata`=0.
  - `errorbit`=0, `busy`=0.
  - The outputs that depend on register contents follow: `zero_flags` all ones, `sign_flags` all zeros, `registers`=0.
  - Reset mid-transaction drops `mem_req` at that edge and does not write the register.
- **ALU writeback:** the result is visible one edge after the command.
- **Request timing:** accepted at edge N means `mem_req` is high after N. `mem_ready` is sampled from edge N+1 onward.
  - A load completes at the first edge ≥N+1 where `mem_ready`=1, with the write visible after that edge.
  - The minimum load or store occupancy is 2 edges.
- **Early `mem_ready`:** `mem_ready` high in IDLE is ignored.
- **Timeout:** with `TIMEOUT`=T, abort occurs at edge N+T when ready never arrives.
- **`errorbit`:** cleared only by reset.

## Test plan
- **Reset and ALU writes:** reset, then ALU-write 0x1234 to r5 with increment 1 → r5=0x1234 and PC=1 after one edge; `zero_flags[5]`=0, `sign_flags[5]`=0.
- **PC wrap and jump:** PC=0xFFFF, increment 1 → PC=0x0000. ALU-write 0x0040 to r0 with increment 1 → PC=0x0041.
- **Load with wait states:** load from memory at 0x0100 into r3, with `mem_ready` arriving 3 cycles after `mem_req`.
  - `busy` and `mem_req` are high for 3 cycles and `mem_addr` is stable.
  - r3 = `mem_rdata` = 0xBEEF; PC advances only on completion.
  - Commands issued during the wait are ignored.
- **Stack store with immediate ready:** store r7=0x00AA to stack at 0x0010, `mem_ready` 1 cycle after `mem_req`.
  - Bus shows `mem_we`=1, `mem_space`=1, `mem_wdata`=0x00AA.
  - The transaction completes in 2 edges; no register changes except PC.
- **Illegal command:** assert `st_mem`&`st_stk` → `errorbit`=1, PC += increment, `mem_req` stays 0.
- **Timeout and mid-transaction reset:**
  - `TIMEOUT`=4 with no ready → abort after 4 wait cycles, `errorbit`=1, destination unchanged.
  - Separately, reset during LOAD_WAIT → `mem_req`=0 and all registers 0 at the next edge.

Source files
------------

// File: rtl/datapath_v2.sv
`default_nettype none
// ============================================================================
// Module   : datapath_v2
// Brief    : Parametrised register-file datapath (r0 = PC) with ALU writeback
//            and a valid/ready memory/stack bus driven by a wait-state FSM.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_v2 #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 16,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = $clog2(NREGS)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   pc_increment,
    input  logic [SEL_W-1:0]       rd_a_sel,
    input  logic [SEL_W-1:0]       rd_b_sel,
    input  logic [SEL_W-1:0]       rd_c_sel,
    output logic [WIDTH-1:0]       rd_a,
    output logic [WIDTH-1:0]       rd_b,
    output logic [WIDTH-1:0]       rd_c,
    input  logic [SEL_W-1:0]       wr_sel,
    input  logic [1:0]             wr_src,
    input  logic                   st_mem,
    input  logic                   st_stk,
    input  logic [WIDTH-1:0]       alu_result,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic                   mem_space,
    output logic [WIDTH-1:0]       mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    input  logic                   mem_ready,
    input  logic [WIDTH-1:0]       mem_rdata,
    output logic                   busy,
    output logic                   errorbit,
    output logic [NREGS-1:0]       zero_flags,
    output logic [NREGS-1:0]       sign_flags,
    output logic [NREGS*WIDTH-1:0] registers
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_WAIT  = 2'd1,
        ST_STORE_WAIT = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  regs_d [NREGS];
    logic [SEL_W-1:0]  ld_sel_q;
    logic              pc_inc_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              mem_space_q;
    logic [WIDTH-1:0]  mem_addr_q;
    logic [WIDTH-1:0]  mem_wdata_q;
    logic              err_q;

    logic              w_idle;
    logic              w_store;
    logic              w_illegal;
    logic              w_alu;
    logic              w_load;
    logic              w_timeout;
    logic [WIDTH-1:0]  w_inc;
    logic [WIDTH-1:0]  w_linc;

    assign w_idle    = (state_q == ST_IDLE);
    assign w_store   = st_mem | st_stk;
    assign w_illegal = (st_mem & st_stk) | (w_store & (wr_src != 2'b00));
    assign w_alu     = (wr_src == 2'b01);
    assign w_load    = wr_src[1];
    assign w_inc     = {{(WIDTH-1){1'b0}}, pc_increment};
    assign w_linc    = {{(WIDTH-1){1'b0}}, pc_inc_q};

    generate
        if (TIMEOUT == 0) begin : g_tmo_off
            assign w_timeout = 1'b0;
        end else begin : g_tmo_on
            // Abort on the wait edge that would complete the TIMEOUT-th empty cycle
            assign w_timeout = !w_idle && !mem_ready && (wait_cnt_q == c_TMO_LAST);
        end
    endgenerate

    always_comb begin
        regs_d = regs_q;
        if (w_idle) begin
            if (w_illegal) begin
                regs_d[0] = regs_q[0] + w_inc;
            end else if (w_alu) begin
                regs_d[wr_sel] = alu_result;
                regs_d[0]      = ((wr_sel == '0) ? alu_result : regs_q[0]) + w_inc;
            end else if (!w_load && !w_store) begin
                regs_d[0] = regs_q[0] + w_inc;
            end
        end else if ((state_q == ST_LOAD_WAIT) && mem_ready) begin
            regs_d[ld_sel_q] = mem_rdata;
            regs_d[0]        = ((ld_sel_q == '0) ? mem_rdata : regs_q[0]) + w_linc;
        end else if (mem_ready || w_timeout) begin
            regs_d[0] = regs_q[0] + w_linc;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            regs_q      <= '{default: '0};
            ld_sel_q    <= '0;
            pc_inc_q    <= 1'b0;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_space_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            regs_q <= regs_d;
            case (state_q)
                ST_IDLE: begin
                    wait_cnt_q <= '0;
                    if (w_illegal) begin
                        err_q <= 1'b1;
                    end else if (w_load) begin
                        state_q     <= ST_LOAD_WAIT;
                        ld_sel_q    <= wr_sel;
                        pc_inc_q    <= pc_increment;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_space_q <= wr_src[0];
                        mem_addr_q  <= alu_result;
                    end else if (w_store) begin
                        state_q     <= ST_STORE_WAIT;
                        pc_inc_q    <= pc_increment;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_space_q <= st_stk;
                        mem_addr_q  <= alu_result;
                        mem_wdata_q <= rd_c;
                    end
                end
                ST_LOAD_WAIT, ST_STORE_WAIT: begin
                    if (mem_ready || w_timeout) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        if (w_timeout) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_a      = regs_q[rd_a_sel];
    assign rd_b      = regs_q[rd_b_sel];
    assign rd_c      = regs_q[rd_c_sel];
    assign busy      = !w_idle;
    assign errorbit  = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_space = mem_space_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_flat
            assign registers[i*WIDTH +: WIDTH] = regs_q[i];
            assign zero_flags[i]               = (regs_q[i] == '0);
            assign sign_flags[i]               = regs_q[i][WIDTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_datapath_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_v2
// Brief    : Directed and randomized bench for datapath_v2 against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_v2;

    localparam int W = 16;
    localparam int N = 16;
    localparam int T = 4;

    logic          clock = 1'b0;
    logic          resetn;
    logic          pc_increment;
    logic [3:0]    rd_a_sel, rd_b_sel, rd_c_sel, wr_sel;
    logic [W-1:0]  rd_a, rd_b, rd_c;
    logic [1:0]    wr_src;
    logic          st_mem, st_stk;
    logic [W-1:0]  alu_result;
    logic          mem_req, mem_we, mem_space;
    logic [W-1:0]  mem_addr, mem_wdata;
    logic          mem_ready;
    logic [W-1:0]  mem_rdata;
    logic          busy, errorbit;
    logic [N-1:0]  zero_flags, sign_flags;
    logic [N*W-1:0] registers;

    datapath_v2 #(.WIDTH(W), .NREGS(N), .TIMEOUT(T)) dut (
        .clock(clock), .resetn(resetn), .pc_increment(pc_increment),
        .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .rd_c_sel(rd_c_sel),
        .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
        .wr_sel(wr_sel), .wr_src(wr_src), .st_mem(st_mem), .st_stk(st_stk),
        .alu_result(alu_result), .mem_req(mem_req), .mem_we(mem_we),
        .mem_space(mem_space), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy),
        .errorbit(errorbit), .zero_flags(zero_flags), .sign_flags(sign_flags),
        .registers(registers)
    );

    initial forever #5 clock = ~clock;

    // Reference model: architectural registers plus at most one outstanding bus transaction
    logic [W-1:0] mregs [N];
    bit           m_err, m_pend, m_we, m_space, m_inc;
    logic [3:0]   m_sel;
    logic [W-1:0] m_addr, m_wdata;
    int           m_wait;
    int           total = 0;
    int           bad = 0;
    bit           cmp_en = 0;

    logic [N*W-1:0] e_flat;
    logic [N-1:0]   e_zero, e_sign;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [W-1:0] inc;
        logic [W-1:0] linc;
        bit sto;
        inc  = {15'd0, pc_increment};
        linc = {15'd0, m_inc};
        sto  = st_mem | st_stk;
        if (!resetn) begin
            for (int i = 0; i < N; i++) mregs[i] = '0;
            m_err = 0; m_pend = 0; m_we = 0; m_space = 0; m_inc = 0;
            m_sel = '0; m_addr = '0; m_wdata = '0; m_wait = 0;
        end else if (m_pend) begin
            if (mem_ready) begin
                if (!m_we) begin
                    if (m_sel == 4'd0) mregs[0] = mem_rdata + linc;
                    else begin
                        mregs[m_sel] = mem_rdata;
                        mregs[0] = mregs[0] + linc;
                    end
                end else begin
                    mregs[0] = mregs[0] + linc;
                end
                m_pend = 0;
            end else begin
                m_wait++;
                if (T != 0 && m_wait == T) begin
                    m_err = 1;
                    mregs[0] = mregs[0] + linc;
                    m_pend = 0;
                end
            end
        end else begin
            if ((st_mem && st_stk) || (sto && wr_src != 2'b00)) begin
                m_err = 1;
                mregs[0] = mregs[0] + inc;
            end else if (wr_src == 2'b01) begin
                if (wr_sel == 4'd0) mregs[0] = alu_result + inc;
                else begin
                    mregs[wr_sel] = alu_result;
                    mregs[0] = mregs[0] + inc;
                end
            end else if (wr_src[1]) begin
                m_pend = 1; m_we = 0; m_space = wr_src[0]; m_sel = wr_sel;
                m_inc = pc_increment; m_addr = alu_result; m_wait = 0;
            end else if (sto) begin
                m_pend = 1; m_we = 1; m_space = st_stk; m_inc = pc_increment;
                m_addr = alu_result; m_wdata = mregs[rd_c_sel]; m_wait = 0;
            end else begin
                mregs[0] = mregs[0] + inc;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #2;
    endtask

    task automatic cmd(input logic [1:0] src, input logic [3:0] sel, input logic [W-1:0] alu,
                       input logic inc, input logic sm, input logic ss);
        wr_src = src; wr_sel = sel; alu_result = alu;
        pc_increment = inc; st_mem = sm; st_stk = ss;
    endtask

    task automatic at_neg();
        @(negedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            for (int i = 0; i < N; i++) begin
                e_flat[i*W +: W] = mregs[i];
                e_zero[i] = (mregs[i] == '0);
                e_sign[i] = mregs[i][W-1];
            end
            chk("registers", registers, e_flat);
            chk("zero_flags", zero_flags, e_zero);
            chk("sign_flags", sign_flags, e_sign);
            chk("rd_a", rd_a, mregs[rd_a_sel]);
            chk("rd_b", rd_b, mregs[rd_b_sel]);
            chk("rd_c", rd_c, mregs[rd_c_sel]);
            chk("busy", busy, m_pend);
            chk("mem_req", mem_req, m_pend);
            chk("errorbit", errorbit, m_err);
            if (m_pend) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", mem_we, m_we);
                chk("mem_space", mem_space, m_space);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
        end
    end

    initial begin
        resetn = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        rd_a_sel = '0; rd_b_sel = '0; rd_c_sel = '0;
        cmd(2'b00, 4'd0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        cmp_en = 1;
        at_neg();
        chk("rst_regs", registers, '0);
        chk("rst_zero", zero_flags, 16'hFFFF);
        chk("rst_sign", sign_flags, 16'h0000);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_space", mem_space, 1'b0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_err", errorbit, 1'b0);
        chk("rst_busy", busy, 1'b0);
        resetn = 1'b1;

        cmd(2'b01, 4'd5, 16'h1234, 1'b1, 1'b0, 1'b0);
        tick();
        cmd(2'b00, 4'd0, '0, 1'b0, 1'b0, 1'b0);
        at_neg();
        chk("alu_r5", registers[5*W +: W], 16'h1234);
        chk("alu_pc", registers[0 +: W], 16'h0001);
        chk("alu_z5", zero_flags[5], 1'b0);
        chk("alu_s5", sign_flags[5], 1'b0);

        cmd(2'b01, 4'd0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        tick();
        cmd(2'b00, 4'd0, '0, 1'b1, 1'b0, 1'b0);
        at_neg();
        chk("pc_ffff", registers[0 +: W], 16'hFFFF);
        tick();
        cmd(2'b01, 4'd0, 16'h0040, 1'b1, 1'b0, 1'b0);
        at_neg();
        chk("pc_wrap", registers[0 +: W], 16'h0000);
        tick();
        cmd(2'b00, 4'd0, '0, 1'b0, 1'b0, 1'b0);
        at_neg();
        chk("pc_jump", registers[0 +: W], 16'h0041);

        cmd(2'b10, 4'd3, 16'h0100, 1'b1, 1'b0, 1'b0);
        tick();
        cmd(2'b01, 4'd3, 16'h5555, 1'b1, 1'b0, 1'b0);
        at_neg();
        chk("ld_busy", busy, 1'b1);
        chk("ld_addr", mem_addr, 16'h0100);
        chk("ld_space", mem_space, 1'b0);
        tick();
        tick();
        at_neg();
        chk("ld_pc_hold", registers[0 +: W], 16'h0041);
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ready = 1'b0;
        cmd(2'b00, 4'd0, '0, 1'b0, 1'b0, 1'b0);
        at_neg();
        chk("ld_r3", registers[3*W +: W], 16'hBEEF);
        chk("ld_pc", registers[0 +: W], 16'h0042);
        chk("ld_done", busy, 1'b0);

        cmd(2'b01, 4'd7, 16'h00AA, 1'b0, 1'b0, 1'b0);
        tick();
        rd_c_sel = 4'd7;
        cmd(2'b00, 4'd0, 16'h0010, 1'b1, 1'b0, 1'b1);
        tick();
        mem_ready = 1'b1;
        cmd(2'b00, 4'd0, '0, 1'b0, 1'b0, 1'b0);
        at_neg();
        chk("st_we", mem_we, 1'b1);
        chk("st_space", mem_space, 1'b1);
        chk("st_wdata", mem_wdata, 16'h00AA);
        chk("st_addr", mem_addr, 16'h0010);
        tick();
        mem_ready = 1'b0;
        at_neg();
        chk("st_done", busy, 1'b0);
        chk("st_pc", registers[0 +: W], 16'h0043);

        cmd(2'b00, 4'd0, '0, 1'b1, 1'b1, 1'b1);
        tick();
        cmd(2'b00, 4'd0, '0, 1'b0, 1'b0, 1'b0);
        at_neg();
        chk("ill_err", errorbit, 1'b1);
        chk("ill_pc", registers[0 +: W], 16'h0044);
        chk("ill_req", mem_req, 1'b0);

        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        cmd(2'b10, 4'd2, 16'h0020, 1'b1, 1'b0, 1'b0);
        tick();
        cmd(2'b00, 4'd0, '0, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        at_neg();
        chk("tmo_wait", busy, 1'b1);
        tick();
        at_neg();
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_err", errorbit, 1'b1);
        chk("tmo_r2", registers[2*W +: W], 16'h0000);
        chk("tmo_pc", registers[0 +: W], 16'h0001);

        cmd(2'b01, 4'd4, 16'h0077, 1'b0, 1'b0, 1'b0);
        tick();
        cmd(2'b10, 4'd4, 16'h0030, 1'b1, 1'b0, 1'b0);
        tick();
        cmd(2'b00, 4'd0, '0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h1111;
        tick();
        at_neg();
        chk("mrst_req", mem_req, 1'b0);
        chk("mrst_regs", registers, '0);
        resetn = 1'b1; mem_ready = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            resetn       = ($urandom_range(0, 149) != 0);
            st_mem       = ($urandom_range(0, 9) == 0);
            st_stk       = ($urandom_range(0, 9) == 0);
            wr_src       = 2'($urandom_range(0, 3));
            if ((st_mem || st_stk) && $urandom_range(0, 3) != 0) wr_src = 2'b00;
            wr_sel       = 4'($urandom);
            rd_a_sel     = 4'($urandom);
            rd_b_sel     = 4'($urandom);
            rd_c_sel     = 4'($urandom);
            alu_result   = 16'($urandom);
            pc_increment = 1'($urandom);
            mem_ready    = ($urandom_range(0, 4) < 2);
            mem_rdata    = 16'($urandom);
            tick();
        end
        at_neg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
